// File: rtl/serial_alu_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
//   state_t      : sequencer FSM states
//   OP_*         : 2-bit operation field of alu_ctl (slice mux select)
//   CTL_*        : full 4-bit alu_ctl codes {ainvert, bnegate, op[1:0]}
//   ctl_is_legal : true for the six supported alu_ctl codes
package serial_alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    function automatic logic ctl_is_legal(input logic [3:0] ctl);
        case (ctl)
            CTL_AND, CTL_OR, CTL_ADD, CTL_SUB, CTL_SLT, CTL_NOR: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/serial_alu_seq_slice.sv
// 1-bit ALU slice with set-less-than support (combinational).
//   in1, in2   : operand bits
//   carryIn    : carry into this bit position
//   ainvert    : invert in1 before use
//   binvert    : invert in2 before use
//   op[1:0]    : 00 AND, 01 OR, 10 ADD, 11 pass 'less'
//   less       : value passed through for op 11
//   result     : selected output bit
//   set        : raw adder sum bit (sign source for SLT on the MSB)
//   overflow   : carryIn ^ carry-out; the slice exports no carry-out,
//                so the caller recovers it as overflow ^ carryIn
module my1BitALU_SLT
    import serial_alu_seq_pkg::*;
(
    input  logic       in1,
    input  logic       in2,
    input  logic       carryIn,
    input  logic       ainvert,
    input  logic       binvert,
    input  logic [1:0] op,
    input  logic       less,
    output logic       result,
    output logic       set,
    output logic       overflow
);

    logic a_eff;
    logic b_eff;
    logic sum;
    logic cout;

    always_comb begin
        a_eff = in1 ^ ainvert;
        b_eff = in2 ^ binvert;
        sum   = a_eff ^ b_eff ^ carryIn;
        cout  = (a_eff & b_eff) | (a_eff & carryIn) | (b_eff & carryIn);
        case (op)
            OP_AND:  result = a_eff & b_eff;
            OP_OR:   result = a_eff | b_eff;
            OP_ADD:  result = sum;
            default: result = less;
        endcase
    end

    assign set      = sum;
    assign overflow = carryIn ^ cout;

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: WIDTH-bit operation computed LSB first, one bit
// per clock, through a single 1-bit ALU slice.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : request strobe, accepted in IDLE or DONE only
//   alu_ctl  : {ainvert, bnegate, op[1:0]}, sampled with start
//   a, b     : operands, sampled with start
//   busy     : high while an operation is in RUN
//   done     : one-cycle pulse when result/flags become valid
//   result   : registered result, held until the next accepted start
//   zero     : result == 0
//   overflow : signed overflow for ADD/SUB, 0 otherwise
//   illegal  : unsupported alu_ctl; result forced to 0
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start
// RUN     | one operand bit per cycle, cnt = 0..WIDTH-1
// DONE    | result valid, done pulse; start here re-enters RUN directly
module serial_alu_seq
    import serial_alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic [3:0]       ctl_q, ctl_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             lt_q, lt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             illegal_q, illegal_d;

    logic s_result;
    logic s_set;
    logic s_ovf;

    my1BitALU_SLT u_slice (
        .in1      (a_sh_q[0]),
        .in2      (b_sh_q[0]),
        .carryIn  (carry_q),
        .ainvert  (ctl_q[3]),
        .binvert  (ctl_q[2]),
        .op       (ctl_q[1:0]),
        .less     (1'b0),
        .result   (s_result),
        .set      (s_set),
        .overflow (s_ovf)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        r_sh_d     = r_sh_q;
        ctl_d      = ctl_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;
        lt_d       = lt_q;
        result_d   = result_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    r_sh_d  = '0;
                    ctl_d   = alu_ctl;
                    // bnegate doubles as the +1 of the two's complement negate
                    carry_d = alu_ctl[2];
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                r_sh_d  = {s_result, r_sh_q[WIDTH-1:1]};
                // overflow ^ carryIn recovers the slice carry-out
                carry_d = s_ovf ^ carry_q;
                cnt_d   = cnt_q + 1'b1;

                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    ovf_d   = s_ovf;
                    // signed less-than stays correct when the subtract overflows
                    lt_d    = s_set ^ s_ovf;

                    // final flags use this cycle's slice outputs, not the
                    // ovf_q/lt_q captured on this same edge
                    if (!ctl_is_legal(ctl_q)) begin
                        result_d   = '0;
                        overflow_d = 1'b0;
                        illegal_d  = 1'b1;
                    end else begin
                        if (ctl_q == CTL_SLT) begin
                            result_d = {{(WIDTH-1){1'b0}}, lt_d};
                        end else begin
                            result_d = r_sh_d;
                        end
                        overflow_d = (ctl_q[1:0] == OP_ADD) ? ovf_d : 1'b0;
                        illegal_d  = 1'b0;
                    end
                    zero_d = (result_d == '0);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            r_sh_q     <= '0;
            ctl_q      <= '0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            lt_q       <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b1;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            r_sh_q     <= r_sh_d;
            ctl_q      <= ctl_d;
            carry_q    <= carry_d;
            ovf_q      <= ovf_d;
            lt_q       <= lt_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
module tb_serial_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   alu_ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         illegal;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0]   ctl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         ovf;
    } vec_t;

    vec_t dvec [11] = '{
        '{4'b0010, 8'h7F, 8'h01, 8'h80, 1'b1},
        '{4'b0110, 8'h05, 8'h05, 8'h00, 1'b0},
        '{4'b0110, 8'h80, 8'h01, 8'h7F, 1'b1},
        '{4'b0111, 8'hFE, 8'h03, 8'h01, 1'b0},
        '{4'b0111, 8'h03, 8'hFE, 8'h00, 1'b0},
        '{4'b0111, 8'h80, 8'h7F, 8'h01, 1'b0},
        '{4'b0000, 8'hF0, 8'h3C, 8'h30, 1'b0},
        '{4'b0001, 8'hF0, 8'h3C, 8'hFC, 1'b0},
        '{4'b1100, 8'hF0, 8'h3C, 8'h03, 1'b0},
        '{4'b0010, 8'hFF, 8'h01, 8'h00, 1'b0},
        '{4'b0110, 8'h7F, 8'hFF, 8'h80, 1'b1}
    };

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .alu_ctl  (alu_ctl),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    // Reference: plain two's complement arithmetic on whole words.
    function automatic void model(input logic [3:0] ctl, input logic [W-1:0] x,
                                  input logic [W-1:0] y, output logic [W-1:0] r,
                                  output logic ovf, output logic ill);
        int sx;
        int sy;
        int s;
        sx  = int'($signed(x));
        sy  = int'($signed(y));
        r   = '0;
        ovf = 1'b0;
        ill = 1'b0;
        case (ctl)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: begin s = sx + sy; r = W'(s); ovf = (s > 127) || (s < -128); end
            4'b0110: begin s = sx - sy; r = W'(s); ovf = (s > 127) || (s < -128); end
            4'b0111: r = (sx < sy) ? W'(1) : W'(0);
            4'b1100: r = ~(x | y);
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic issue(input logic [3:0] ctl, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        alu_ctl = ctl;
        a       = x;
        b       = y;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // counts rising edges from now until done is seen (bounded)
    task automatic wait_done(output int n);
        n = 0;
        while (n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        alu_ctl = '0;
        a       = '0;
        b       = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, result, zero, overflow, illegal} !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b result=%h zero=%b ovf=%b ill=%b",
                     busy, done, result, zero, overflow, illegal);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        int n;
        for (int i = 0; i < 11; i++) begin
            issue(dvec[i].ctl, dvec[i].a, dvec[i].b);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL dir_busy[%0d] got %b want 1", i, busy);
            end
            wait_done(n);
            checks++;
            if (n !== 8) begin
                errors++;
                $display("FAIL dir_latency[%0d] got %0d want 8", i, n);
            end
            checks++;
            if ({result, overflow, zero, illegal, busy} !==
                {dvec[i].r, dvec[i].ovf, dvec[i].r == 8'h00, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL dir_out[%0d] got r=%h ovf=%b z=%b ill=%b busy=%b want r=%h ovf=%b",
                         i, result, overflow, zero, illegal, busy, dvec[i].r, dvec[i].ovf);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || result !== dvec[i].r) begin
                errors++;
                $display("FAIL dir_hold[%0d] got done=%b r=%h want done=0 r=%h",
                         i, done, result, dvec[i].r);
            end
        end
    endtask

    task automatic test_random();
        int n;
        logic [3:0]   ctl;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] er;
        logic         eo;
        logic         ei;
        logic [3:0]   codes [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) ctl = 4'($urandom);
            else                           ctl = codes[$urandom_range(0, 5)];
            x = W'($urandom);
            y = W'($urandom);
            model(ctl, x, y, er, eo, ei);
            issue(ctl, x, y);
            wait_done(n);
            checks++;
            if (n !== 8 || {result, overflow, zero, illegal} !== {er, eo, er == 8'h00, ei}) begin
                errors++;
                $display("FAIL rand[%0d] ctl=%b a=%h b=%h got n=%0d r=%h ovf=%b z=%b ill=%b want r=%h ovf=%b ill=%b",
                         i, ctl, x, y, n, result, overflow, zero, illegal, er, eo, ei);
            end
        end
    endtask

    task automatic test_mid_start();
        int n;
        int extra;
        issue(4'b0010, 8'h12, 8'h34);
        repeat (3) @(negedge clk);
        alu_ctl = 4'b0001;
        a       = 8'hFF;
        b       = 8'hFF;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_done(n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL mid_start_latency got %0d want 4", n);
        end
        checks++;
        if (result !== 8'h46 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_start_result got %h ovf=%b want 46 ovf=0", result, overflow);
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL mid_start_no_requeue got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(4'b0110, 8'h10, 8'h20);
        wait_done(n);
        alu_ctl = 4'b0000;
        a       = 8'hAA;
        b       = 8'h0F;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || result !== 8'hF0) begin
            errors++;
            $display("FAIL b2b_accept got busy=%b done=%b r=%h want busy=1 done=0 r=f0",
                     busy, done, result);
        end
        wait_done(n);
        checks++;
        if (n !== 8 || result !== 8'h0A || zero !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got n=%0d r=%h z=%b want n=8 r=0a z=0", n, result, zero);
        end
    endtask

    task automatic test_illegal();
        int n;
        issue(4'b0101, 8'h33, 8'h44);
        wait_done(n);
        checks++;
        if (n !== 8 || {result, zero, overflow, illegal} !== {8'h00, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL illegal got n=%0d r=%h z=%b ovf=%b ill=%b want n=8 r=00 z=1 ovf=0 ill=1",
                     n, result, zero, overflow, illegal);
        end
        issue(4'b0010, 8'h01, 8'h02);
        wait_done(n);
        checks++;
        if (illegal !== 1'b0 || result !== 8'h03) begin
            errors++;
            $display("FAIL illegal_clear got ill=%b r=%h want ill=0 r=03", illegal, result);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        issue(4'b0010, 8'h20, 8'h30);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || result !== 8'h03) begin
            errors++;
            $display("FAIL pre_reset got busy=%b r=%h want busy=1 r=03", busy, result);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, zero, overflow, illegal} !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_run got busy=%b done=%b r=%h z=%b ovf=%b ill=%b",
                     busy, done, result, zero, overflow, illegal);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_no_done got %0d active cycles want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_mid_start();
        test_back_to_back();
        test_illegal();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
